// File: rtl/decode_queue_reader.sv
// Read side of the dual decode queues: pops q0/q1 in program order under a
// mirrored 1-bit pointer and presents up to two age-ordered micro-ops to dispatch.
module decode_queue_reader #(
    parameter int DWID = 128
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            q0_valid_i,
    input  logic [DWID-1:0] q0_data_i,
    output logic            q0_ren_o,
    input  logic            q1_valid_i,
    input  logic [DWID-1:0] q1_data_i,
    output logic            q1_ren_o,
    output logic            disp0_valid_o,
    output logic [DWID-1:0] disp0_data_o,
    input  logic            disp0_ready_i,
    output logic            disp1_valid_o,
    output logic [DWID-1:0] disp1_data_o,
    input  logic            disp1_ready_i,
    output logic            rptr_o
);

    logic            s0_valid, s1_valid;
    logic [DWID-1:0] s0_data, s1_data;
    logic            rptr;

    logic            fire0, fire1;
    logic [1:0]      occ, occ_after, free_cnt;
    logic            h_valid, t_valid;
    logic [DWID-1:0] h_data, t_data;
    logic            pop_h, pop_t;

    logic            n0_valid, n1_valid;
    logic [DWID-1:0] n0_data, n1_data;

    always_comb begin
        fire0     = s0_valid & disp0_ready_i;
        fire1     = fire0 & s1_valid & disp1_ready_i;
        occ       = {1'b0, s0_valid} + {1'b0, s1_valid};
        occ_after = occ - {1'b0, fire0} - {1'b0, fire1};
        free_cnt  = 2'd2 - occ_after;
        h_valid   = rptr ? q1_valid_i : q0_valid_i;
        t_valid   = rptr ? q0_valid_i : q1_valid_i;
        h_data    = rptr ? q1_data_i  : q0_data_i;
        t_data    = rptr ? q0_data_i  : q1_data_i;
        // The tail queue is only ever popped together with the head, never alone.
        pop_h     = rst_n_i & ~flush_i & (free_cnt != 2'd0) & h_valid;
        pop_t     = pop_h & (free_cnt == 2'd2) & t_valid;
    end

    assign q0_ren_o = rptr ? pop_t : pop_h;
    assign q1_ren_o = rptr ? pop_h : pop_t;

    // Compact survivors toward slot0, then append popped entries oldest first.
    always_comb begin
        n0_valid = s0_valid;
        n0_data  = s0_data;
        n1_valid = s1_valid;
        n1_data  = s1_data;
        if (fire1) begin
            n0_valid = 1'b0;
            n1_valid = 1'b0;
        end else if (fire0) begin
            n0_valid = s1_valid;
            n0_data  = s1_data;
            n1_valid = 1'b0;
        end
        if (!n0_valid) begin
            if (pop_h) begin
                n0_valid = 1'b1;
                n0_data  = h_data;
            end
            if (pop_t) begin
                n1_valid = 1'b1;
                n1_data  = t_data;
            end
        end else if (!n1_valid && pop_h) begin
            n1_valid = 1'b1;
            n1_data  = h_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s0_data  <= '0;
            s1_data  <= '0;
            rptr     <= 1'b0;
        end else begin
            s0_valid <= n0_valid;
            s1_valid <= n1_valid;
            s0_data  <= n0_data;
            s1_data  <= n1_data;
            rptr     <= rptr ^ (pop_h ^ pop_t);
        end
    end

    assign disp0_valid_o = s0_valid;
    assign disp0_data_o  = s0_data;
    assign disp1_valid_o = s1_valid;
    assign disp1_data_o  = s1_data;
    assign rptr_o        = rptr;

endmodule
